// File: rtl/n101_jtag_pkg.sv
// n101_jtag_pkg: TAP states, instruction codes, DTMCS value and DMI widths
package n101_jtag_pkg;
  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR, TAP_PAUSE_DR, TAP_EXIT2_DR,
    TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
  } tap_state_e;
  localparam logic [4:0] INS_IDCODE = 5'h01;
  localparam logic [4:0] INS_DTMCS = 5'h10;
  localparam logic [4:0] INS_DMI = 5'h11;
  localparam logic [31:0] DTMCS_VAL = {17'b0, 3'd0, 2'b00, 6'd7, 4'd1};
  localparam int DMI_ABITS = 7;
  localparam int DMI_DATA_W = 32;
  localparam int DMI_OP_W = 2;
  localparam int DMI_REQ_W = DMI_ABITS + DMI_DATA_W + DMI_OP_W;
  localparam int DMI_RSP_W = DMI_DATA_W + 2;
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:      n = tms ? TAP_TLR : TAP_RTI;
      TAP_RTI:      n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: n = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: n = tms ? TAP_UPD_DR : TAP_SHIFT_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   n = tms ? TAP_TLR : TAP_CAP_IR;
      TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: n = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: n = tms ? TAP_UPD_IR : TAP_SHIFT_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR : TAP_RTI;
      default:      n = TAP_TLR;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/n101_sync2.sv
// n101_sync2: two-flop synchronizer for one asynchronous input
module n101_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/n101_jtag_tap_sync.sv
// n101_jtag_tap_sync: clk-sampled JTAG TAP with IDCODE, DTMCS, DMI and BYPASS registers
module n101_jtag_tap_sync
  import n101_jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h1E200A6D,
  parameter int IR_LEN = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 jtag_tck,
  input  logic                 jtag_tms,
  input  logic                 jtag_tdi,
  input  logic                 jtag_trst,
  output logic                 jtag_tdo,
  output logic                 jtag_drv_tdo,
  output logic                 dmi_req_valid,
  input  logic                 dmi_req_ready,
  output logic [DMI_REQ_W-1:0] dmi_req_data,
  input  logic                 dmi_rsp_valid,
  input  logic [DMI_RSP_W-1:0] dmi_rsp_data,
  output logic                 dmi_rsp_ready
);
  logic tck_s, tms_s, tdi_s, trst_s, tck_q;
  tap_state_e state, state_nx;
  logic [IR_LEN-1:0] ir, ir_sr;
  logic [DMI_REQ_W-1:0] dr_sr, dr_cap, dr_shift;
  logic [DMI_RSP_W-1:0] rsp_q;
  logic rsp_held, tck_rise, tck_fall, act, dmi_sel, dtmcs_sel, idcode_sel;
  n101_sync2 u_sync_tck (.clk(clk), .rst_n(rst_n), .d(jtag_tck), .q(tck_s));
  n101_sync2 u_sync_tms (.clk(clk), .rst_n(rst_n), .d(jtag_tms), .q(tms_s));
  n101_sync2 u_sync_tdi (.clk(clk), .rst_n(rst_n), .d(jtag_tdi), .q(tdi_s));
  n101_sync2 u_sync_trst (.clk(clk), .rst_n(rst_n), .d(jtag_trst), .q(trst_s));
  assign tck_rise = tck_s & ~tck_q;
  assign tck_fall = ~tck_s & tck_q;
  assign act = tck_rise & ~trst_s;
  assign dmi_sel = ir == IR_LEN'(INS_DMI);
  assign dtmcs_sel = ir == IR_LEN'(INS_DTMCS);
  assign idcode_sel = ir == IR_LEN'(INS_IDCODE);
  assign dmi_rsp_ready = ~rsp_held;
  always_comb begin
    state_nx = trst_s ? TAP_TLR : tck_rise ? tap_next(state, tms_s) : state;
    dr_cap = idcode_sel ? DMI_REQ_W'(IDCODE) : dtmcs_sel ? DMI_REQ_W'(DTMCS_VAL) :
             dmi_sel ? (rsp_held ? DMI_REQ_W'(rsp_q) : DMI_REQ_W'(2'b11)) : '0;
    dr_shift = dmi_sel ? {tdi_s, dr_sr[DMI_REQ_W-1:1]} :
               (idcode_sel | dtmcs_sel) ? {9'b0, tdi_s, dr_sr[31:1]} : {40'b0, tdi_s};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= TAP_TLR;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tck_q <= 1'b0;
      ir <= IR_LEN'(INS_IDCODE);
      ir_sr <= '0;
      dr_sr <= '0;
    end else begin
      tck_q <= tck_s;
      if (trst_s || state == TAP_TLR) ir <= IR_LEN'(INS_IDCODE);
      else if (act && state == TAP_UPD_IR) ir <= ir_sr;
      if (act && state == TAP_CAP_IR) ir_sr <= IR_LEN'(1);
      else if (act && state == TAP_SHIFT_IR) ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
      if (act && state == TAP_CAP_DR) dr_sr <= dr_cap;
      else if (act && state == TAP_SHIFT_DR) dr_sr <= dr_shift;
    end
  // DMI request is held until accepted; a new Update-DR while pending is dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dmi_req_valid <= 1'b0;
      dmi_req_data <= '0;
      rsp_held <= 1'b0;
      rsp_q <= '0;
    end else begin
      if (act && state == TAP_UPD_DR && dmi_sel && dr_sr[DMI_OP_W-1:0] != '0 && !dmi_req_valid) begin
        dmi_req_valid <= 1'b1;
        dmi_req_data <= dr_sr;
      end else if (dmi_req_valid && dmi_req_ready) dmi_req_valid <= 1'b0;
      if (dmi_rsp_valid && dmi_rsp_ready) begin
        rsp_held <= 1'b1;
        rsp_q <= dmi_rsp_data;
      end else if (act && state == TAP_CAP_DR && dmi_sel) rsp_held <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      jtag_tdo <= 1'b0;
      jtag_drv_tdo <= 1'b0;
    end else if (tck_fall) begin
      jtag_drv_tdo <= state == TAP_SHIFT_IR || state == TAP_SHIFT_DR;
      jtag_tdo <= state == TAP_SHIFT_IR ? ir_sr[0] : state == TAP_SHIFT_DR ? dr_sr[0] : jtag_tdo;
    end
endmodule
